// File: rtl/dbus_driver.sv
// Four-phase (T1-T4) single-beat transfer sequencer for the kept tri-state data bus.
// Strong driver for write data in T2-T4 and the sampling point for read data at the end of T3.
module dbus_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             ack_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             busy_o,
  output logic             rd_n_o,
  output logic             wr_n_o,
  inout  wire  [WIDTH-1:0] d_io
);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_T1   = 5'b00010,
    S_T2   = 5'b00100,
    S_T3   = 5'b01000,
    S_T4   = 5'b10000
  } state_t;

  state_t           state_q, state_d;
  logic             cmd_we_q, cmd_we_d;
  logic [WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             drive_en;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cmd_we_q   <= 1'b0;
      cmd_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_we_q   <= cmd_we_d;
      cmd_data_q <= cmd_data_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_we_d   = cmd_we_q;
    cmd_data_d = cmd_data_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          cmd_we_d   = we_i;
          cmd_data_d = wdata_i;
          state_d    = S_T1;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        state_d = S_T4;
        if (!cmd_we_q) rdata_d = d_io;
      end
      S_T4: begin
        // A still-asserted request chains straight into T1; T1 is the turnaround.
        if (req_i) begin
          cmd_we_d   = we_i;
          cmd_data_d = wdata_i;
          state_d    = S_T1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode only from registered state, never from the inputs.
  assign ack_o    = (state_q == S_T4);
  assign busy_o   = (state_q != S_IDLE);
  assign rd_n_o   = ~(~cmd_we_q & ((state_q == S_T2) | (state_q == S_T3)));
  assign wr_n_o   = ~(cmd_we_q & (state_q == S_T3));
  assign drive_en = cmd_we_q & ((state_q == S_T2) | (state_q == S_T3) | (state_q == S_T4));
  assign d_io     = drive_en ? cmd_data_q : {WIDTH{1'bz}};
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_dbus_driver.sv
// Directed bench for dbus_driver: an external device answers reads while rd_n is low and a
// probe/keeper drives a known value whenever the DUT must be released, exposing any stray drive.
module tb_dbus_driver;
  logic       clk = 1'b0;
  logic       reset;
  logic       req, we;
  logic [7:0] wdata;
  logic       ack, busy, rd_n, wr_n;
  logic [7:0] rdata;
  wire  [7:0] d;

  logic       dev_on;
  logic [7:0] dev_val;
  logic       pr_en;
  logic [7:0] pr_val;
  logic [7:0] exp_d;
  int         total = 0;
  int         bad = 0;

  // The keeper model stands back while the DUT owns the bus, as a weak driver would.
  assign d = (dev_on && !rd_n) ? dev_val : (pr_en ? pr_val : 8'hzz);

  dbus_driver #(.WIDTH(8)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .we_i(we), .wdata_i(wdata),
    .ack_o(ack), .rdata_o(rdata), .busy_o(busy), .rd_n_o(rd_n), .wr_n_o(wr_n), .d_io(d)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    pr_en = 1'b1; pr_val = 8'h5A;
    #1;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (rd_n !== 1'b1) begin bad++; $display("FAIL rst_rd_n got=%b exp=1", rd_n); end
    total++; if (wr_n !== 1'b1) begin bad++; $display("FAIL rst_wr_n got=%b exp=1", wr_n); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL rst_d_released got=%h exp=5a", d); end
    pr_en = 1'b0;
  endtask

  // req is already high when reset drops, so the first edge after release accepts it.
  task automatic test_write;
    req = 1'b1; we = 1'b1; wdata = 8'hA5;
    @(negedge clk) reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) begin req = 1'b0; wdata = 8'h00; end
      pr_en = (c == 1 || c == 5); pr_val = 8'h5A;
      #1;
      exp_d = pr_en ? 8'h5A : 8'hA5;
      total++; if (d !== exp_d) begin bad++; $display("FAIL wr_d c=%0d got=%h exp=%h", c, d, exp_d); end
      total++; if (wr_n !== (c != 3)) begin bad++; $display("FAIL wr_wr_n c=%0d got=%b", c, wr_n); end
      total++; if (rd_n !== 1'b1) begin bad++; $display("FAIL wr_rd_n c=%0d got=%b exp=1", c, rd_n); end
      total++; if (ack !== (c == 4)) begin bad++; $display("FAIL wr_ack c=%0d got=%b", c, ack); end
      total++; if (busy !== (c <= 4)) begin bad++; $display("FAIL wr_busy c=%0d got=%b", c, busy); end
    end
    pr_en = 1'b0;
  endtask

  task automatic test_read;
    dev_on = 1'b1; dev_val = 8'h3C;
    req = 1'b1; we = 1'b0; wdata = 8'hFF;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) req = 1'b0;
      pr_en = (c == 1 || c == 4 || c == 5); pr_val = 8'h00;
      #1;
      exp_d = (c == 2 || c == 3) ? 8'h3C : 8'h00;
      total++; if (d !== exp_d) begin bad++; $display("FAIL rd_d c=%0d got=%h exp=%h", c, d, exp_d); end
      total++; if (rd_n !== !(c == 2 || c == 3)) begin bad++; $display("FAIL rd_rd_n c=%0d got=%b", c, rd_n); end
      total++; if (wr_n !== 1'b1) begin bad++; $display("FAIL rd_wr_n c=%0d got=%b exp=1", c, wr_n); end
      total++; if (ack !== (c == 4)) begin bad++; $display("FAIL rd_ack c=%0d got=%b", c, ack); end
      if (c >= 4) begin
        total++; if (rdata !== 8'h3C) begin bad++; $display("FAIL rd_rdata c=%0d got=%h exp=3c", c, rdata); end
      end
    end
    pr_en = 1'b0;
    req = 1'b1; we = 1'b1; wdata = 8'h11;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) req = 1'b0;
      #1;
      if (c >= 2 && c <= 4) begin
        total++; if (d !== 8'h11) begin bad++; $display("FAIL rdw_d c=%0d got=%h exp=11", c, d); end
      end
      total++; if (rdata !== 8'h3C) begin bad++; $display("FAIL rdw_rdata_hold c=%0d got=%h exp=3c", c, rdata); end
    end
    dev_on = 1'b0;
  endtask

  task automatic test_back_to_back;
    int ph;
    dev_on = 1'b1; dev_val = 8'hC3;
    req = 1'b1; we = 1'b1; wdata = 8'h55;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 4) begin we = 1'b0; wdata = 8'hFF; end
      if (c == 8) begin we = 1'b1; wdata = 8'hAA; end
      if (c == 12) req = 1'b0;
      ph = (c <= 12) ? ((c - 1) % 4 + 1) : 0;
      pr_en = (ph <= 1) || (c == 8); pr_val = 8'h00;
      #1;
      if (c >= 2 && c <= 4) exp_d = 8'h55;
      else if (c == 6 || c == 7) exp_d = 8'hC3;
      else if (c >= 10 && c <= 12) exp_d = 8'hAA;
      else exp_d = 8'h00;
      total++; if (d !== exp_d) begin bad++; $display("FAIL b2b_d c=%0d got=%h exp=%h", c, d, exp_d); end
      total++; if (ack !== (c == 4 || c == 8 || c == 12)) begin bad++; $display("FAIL b2b_ack c=%0d got=%b", c, ack); end
      total++; if (busy !== (c <= 12)) begin bad++; $display("FAIL b2b_busy c=%0d got=%b", c, busy); end
      total++; if (rd_n !== !(c == 6 || c == 7)) begin bad++; $display("FAIL b2b_rd_n c=%0d got=%b", c, rd_n); end
      total++; if (wr_n !== !(c == 3 || c == 11)) begin bad++; $display("FAIL b2b_wr_n c=%0d got=%b", c, wr_n); end
      if (c >= 8) begin
        total++; if (rdata !== 8'hC3) begin bad++; $display("FAIL b2b_rdata c=%0d got=%h exp=c3", c, rdata); end
      end
    end
    pr_en = 1'b0; dev_on = 1'b0;
  endtask

  task automatic test_keeper;
    req = 1'b1; we = 1'b1; wdata = 8'h7E;
    pr_val = 8'h7E;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (c == 1 || c == 6 || c == 11) req = 1'b0;
      if (c == 5) begin req = 1'b1; we = 1'b0; wdata = 8'hFF; end
      if (c == 10) begin req = 1'b1; we = 1'b1; wdata = 8'h81; end
      pr_en = (c >= 5) && !(c >= 12 && c <= 14);
      #1;
      if (c >= 2 && c <= 4) exp_d = 8'h7E;
      else if (c >= 12 && c <= 14) exp_d = 8'h81;
      else exp_d = 8'h7E;
      if (c >= 2) begin
        total++; if (d !== exp_d) begin bad++; $display("FAIL kp_d c=%0d got=%h exp=%h", c, d, exp_d); end
      end
      total++; if (rd_n !== !(c == 7 || c == 8)) begin bad++; $display("FAIL kp_rd_n c=%0d got=%b", c, rd_n); end
      if (c >= 9) begin
        total++; if (rdata !== 8'h7E) begin bad++; $display("FAIL kp_rdata c=%0d got=%h exp=7e", c, rdata); end
      end
    end
    pr_en = 1'b0;
  endtask

  task automatic test_reset_mid_write;
    req = 1'b1; we = 1'b1; wdata = 8'h96;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 1) req = 1'b0;
    end
    total++; if (wr_n !== 1'b0 || d !== 8'h96) begin bad++; $display("FAIL mid_pre wr_n=%b d=%h exp=0/96", wr_n, d); end
    reset = 1'b1;
    pr_en = 1'b1; pr_val = 8'h00;
    #1;
    total++; if (d !== 8'h00) begin bad++; $display("FAIL mid_d_released got=%h exp=00", d); end
    total++; if (wr_n !== 1'b1) begin bad++; $display("FAIL mid_wr_n got=%b exp=1", wr_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL mid_ack got=%b exp=0", ack); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL mid_rdata got=%h exp=00", rdata); end
    for (int c = 1; c <= 3; c++) begin
      step();
      total++; if (ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_hold c=%0d ack=%b busy=%b exp=0/0", c, ack, busy); end
    end
    @(negedge clk) reset = 1'b0;
    step();
    total++; if (busy !== 1'b0 || ack !== 1'b0) begin bad++; $display("FAIL mid_after busy=%b ack=%b exp=0/0", busy, ack); end
    pr_en = 1'b0;
  endtask

  task automatic test_capture_isolation;
    req = 1'b1; we = 1'b1; wdata = 8'h0F;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) begin req = 1'b0; we = 1'b0; end
      if (c == 2) wdata = 8'hF0;
      pr_en = (c == 1 || c == 5); pr_val = 8'h00;
      #1;
      exp_d = pr_en ? 8'h00 : 8'h0F;
      total++; if (d !== exp_d) begin bad++; $display("FAIL iso_d c=%0d got=%h exp=%h", c, d, exp_d); end
      total++; if (wr_n !== (c != 3)) begin bad++; $display("FAIL iso_wr_n c=%0d got=%b", c, wr_n); end
    end
    pr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; wdata = 8'h00;
    dev_on = 1'b0; dev_val = 8'h00; pr_en = 1'b0; pr_val = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_keeper();
    test_reset_mid_write();
    test_capture_isolation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
